calc_cmd_issuer: RTL and testbench

Command-side front end for the combinational calculator datapath. It accepts operation requests over a valid/ready channel and buffers them in a small FIFO. It drives the calculator's opcode, operand and operand-select inputs, holds them stable for two cycles, and captures the registered result and overflow-based valid. Each outcome is returned in request order as a tagged response over a second valid/ready channel.

---
 rtl/calc_cmd_issuer.sv | 248 ++++++++++++++++++++++++
 tb/tb_calc_cmd_issuer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_issuer.sv
// ---------------------------------------------------------------------------
// calc_cmd_issuer
//
// Command-side front end for the combinational calculator datapath.
// Requests are queued in a DEPTH-entry FIFO, popped one at a time into a
// command register, driven onto the calculator for two cycles (ISSUE then
// CAPTURE), and answered in acceptance order with a tagged response.
//
// Ports
//   calc_clock, calc_rst_n        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready           request channel
//   cmd_opcode/op1/op2/sel/tag    request payload (1=SUM 2=MULT 3=SUB 4=SQRT)
//   rsp_valid/rsp_ready           response channel
//   rsp_data/rsp_err/rsp_tag      response payload (data is 0 when err=1)
//   calc_opcode/op_in1/op_in2/op_in_sel   to calculator (zero when not issuing)
//   calc_result, calc_valid_res   from calculator (result registered inside it,
//                                 valid_res combinational, low on overflow)
//   busy                          FSM not idle or FIFO not empty
//   count                         FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A source holds its payload stable while valid is high and ready is low;
// here rsp_valid and its payload are all register outputs, and cmd_ready depends
// only on registered occupancy (no combinational path from cmd_valid).
// ---------------------------------------------------------------------------
module calc_cmd_issuer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int TW    = 4
) (
    input  logic                     calc_clock,
    input  logic                     calc_rst_n,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [DW-1:0]            cmd_op1,
    input  logic [DW-1:0]            cmd_op2,
    input  logic                     cmd_sel,
    input  logic [TW-1:0]            cmd_tag,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*DW-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic [TW-1:0]            rsp_tag,

    output logic [2:0]               calc_opcode,
    output logic [DW-1:0]            calc_op_in1,
    output logic [DW-1:0]            calc_op_in2,
    output logic                     calc_op_in_sel,
    input  logic [2*DW-1:0]          calc_result,
    input  logic                     calc_valid_res,

    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // FIFO entry layout: {opcode, op1, op2, sel, tag}
    localparam int EW = 3 + 2*DW + 1 + TW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    logic [EW-1:0]   head;
    logic [2:0]      head_opcode;
    logic [DW-1:0]   head_op1;
    logic [DW-1:0]   head_op2;
    logic            head_sel;
    logic [TW-1:0]   head_tag;
    logic            head_legal;

    // ------------------------------------------------------------------
    // FSM and command/response registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      opcode_q, opcode_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            sel_q, sel_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic            ok_q, ok_d;
    logic [2*DW-1:0] data_q, data_d;
    logic            err_q, err_d;

    // Ready is held low while reset is asserted so nothing is accepted into a
    // FIFO that is being flushed.
    assign cmd_ready = calc_rst_n && (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);

    assign head = mem_q[rd_ptr_q];
    assign {head_opcode, head_op1, head_op2, head_sel, head_tag} = head;
    assign head_legal = (head_opcode != 3'd0) && (head_opcode <= 3'd4);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: the pointers and count define which entries are live.
    always_ff @(posedge calc_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_opcode, cmd_op1, cmd_op2, cmd_sel, cmd_tag};
        end
    end

    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        sel_d          = sel_q;
        tag_d          = tag_q;
        ok_d           = ok_q;
        data_d         = data_q;
        err_d          = err_q;
        calc_opcode    = 3'd0;
        calc_op_in1    = '0;
        calc_op_in2    = '0;
        calc_op_in_sel = 1'b0;
        rsp_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    opcode_d = head_opcode;
                    op1_d    = head_op1;
                    op2_d    = head_op2;
                    sel_d    = head_sel;
                    tag_d    = head_tag;
                    if (head_legal) begin
                        state_d = ISSUE;
                    end else begin
                        // Illegal opcodes are answered directly; the
                        // calculator never sees them.
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                calc_opcode    = opcode_q;
                calc_op_in1    = op1_q;
                calc_op_in2    = op2_q;
                calc_op_in_sel = sel_q;
                ok_d           = calc_valid_res;
                state_d        = CAPTURE;
            end
            CAPTURE: begin
                // Inputs stay identical so the calculator's registered result
                // and its combinational valid both describe this command.
                calc_opcode    = opcode_q;
                calc_op_in1    = op1_q;
                calc_op_in2    = op2_q;
                calc_op_in_sel = sel_q;
                err_d          = ~(ok_q & calc_valid_res);
                data_d         = err_d ? '0 : calc_result;
                state_d        = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge calc_clock or negedge calc_rst_n) begin
        if (!calc_rst_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sel_q    <= 1'b0;
            tag_q    <= '0;
            ok_q     <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            ok_q     <= ok_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign rsp_data = data_q;
    assign rsp_err  = err_q;
    assign rsp_tag  = tag_q;
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign count    = count_q;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Testbench for calc_cmd_issuer: directed vectors with hand-computed
// expectations, a behavioural calculator model, and a response scoreboard.
module tb_calc_cmd_issuer;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TW = 4;
  localparam int SW = 1 + TW + 2*DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic cmd_valid, cmd_ready, cmd_sel;
  logic [2:0] cmd_opcode;
  logic [DW-1:0] cmd_op1, cmd_op2;
  logic [TW-1:0] cmd_tag;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [2*DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic [2:0] calc_opcode;
  logic [DW-1:0] calc_op_in1, calc_op_in2;
  logic calc_op_in_sel;
  logic [2*DW-1:0] calc_result;
  logic calc_valid_res;
  logic busy;
  logic [$clog2(DEPTH):0] count;

  calc_cmd_issuer #(.DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
    .calc_clock(clk),
    .calc_rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_op1(cmd_op1),
    .cmd_op2(cmd_op2),
    .cmd_sel(cmd_sel),
    .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .rsp_tag(rsp_tag),
    .calc_opcode(calc_opcode),
    .calc_op_in1(calc_op_in1),
    .calc_op_in2(calc_op_in2),
    .calc_op_in_sel(calc_op_in_sel),
    .calc_result(calc_result),
    .calc_valid_res(calc_valid_res),
    .busy(busy),
    .count(count)
  );

  // ---------------- calculator model ----------------
  function automatic logic [DW-1:0] isqrt(input logic [DW-1:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[DW-1:0];
  endfunction

  // Returns {valid, result}
  function automatic logic [2*DW:0] calc_fn(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic s);
    logic [DW:0] w;
    case (op)
      3'd1: begin
        w = {1'b0, a} + {1'b0, b};
        return {~w[DW], {DW{1'b0}}, w[DW-1:0]};
      end
      3'd2: return {1'b1, {{DW{1'b0}}, a} * {{DW{1'b0}}, b}};
      3'd3: begin
        w = {1'b0, b} - {1'b0, a};
        return {~w[DW], {DW{1'b0}}, w[DW-1:0]};
      end
      3'd4: return {1'b1, {DW{1'b0}}, isqrt(s ? a : b)};
      default: return {1'b1, {(2*DW){1'b0}}};
    endcase
  endfunction

  logic [2*DW:0] calc_out;
  always_comb calc_out = calc_fn(calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel);
  assign calc_valid_res = calc_out[2*DW];
  always @(posedge clk) calc_result <= calc_out[2*DW-1:0];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic run_one(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic s, input logic [TW-1:0] tg,
                         input int exp_lat, input logic [2*DW-1:0] exp_data,
                         input logic exp_err);
    int lat;
    int opc;
    int match;
    lat = 0;
    opc = 0;
    match = 0;
    cmd_valid = 1'b1;
    cmd_opcode = op;
    cmd_op1 = a;
    cmd_op2 = b;
    cmd_sel = s;
    cmd_tag = tg;
    check({name, "_ready"}, 72'(cmd_ready), 72'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (calc_opcode != 3'd0) opc++;
      if ({calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel} == {op, a, b, s}) match++;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({name, "_lat"}, 72'(lat), 72'(exp_lat));
    check({name, "_opcycles"}, 72'(opc), 72'((exp_lat == 1) ? 0 : 2));
    check({name, "_opmatch"}, 72'(match), 72'((exp_lat == 1) ? 0 : 2));
    check({name, "_data"}, 72'(rsp_data), 72'(exp_data));
    check({name, "_err"}, 72'(rsp_err), 72'(exp_err));
    check({name, "_tag"}, 72'(rsp_tag), 72'(tg));
    @(posedge clk);
    @(negedge clk);
    check({name, "_vld_after"}, 72'(rsp_valid), 72'(0));
    check({name, "_busy_after"}, 72'(busy), 72'(0));
  endtask

  task automatic push_sum(input logic [TW-1:0] tg, input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_valid = 1'b1;
    cmd_opcode = 3'd1;
    cmd_op1 = a;
    cmd_op2 = b;
    cmd_sel = 1'b0;
    cmd_tag = tg;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    logic [SW-1:0] exp_e;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_opcode = '0;
    cmd_op1 = '0;
    cmd_op2 = '0;
    cmd_sel = 1'b0;
    cmd_tag = '0;
    rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 72'(rsp_valid), 72'(0));
    check("rst_rsp_data", 72'(rsp_data), 72'(0));
    check("rst_rsp_err", 72'(rsp_err), 72'(0));
    check("rst_rsp_tag", 72'(rsp_tag), 72'(0));
    check("rst_count", 72'(count), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_calc", 72'({calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel}), 72'(0));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 72'(cmd_ready), 72'(1));
    check("post_rst_busy", 72'(busy), 72'(0));
    check("post_rst_count", 72'(count), 72'(0));

    // Main function, directed vectors
    run_one("sum_3_4", 3'd1, 32'd3, 32'd4, 1'b0, 4'd1, 3, 64'd7, 1'b0);
    run_one("sum_ovf", 3'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd2, 3, 64'd0, 1'b1);
    run_one("sub_borrow", 3'd3, 32'd5, 32'd3, 1'b0, 4'd3, 3, 64'd0, 1'b1);
    run_one("sub_ok", 3'd3, 32'd3, 32'd5, 1'b0, 4'd4, 3, 64'd2, 1'b0);
    run_one("mult", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd5, 3, 64'h1_FFFF_FFFE, 1'b0);
    run_one("sqrt_sel1", 3'd4, 32'd16, 32'd81, 1'b1, 4'd6, 3, 64'd4, 1'b0);
    run_one("sqrt_sel0", 3'd4, 32'd16, 32'd81, 1'b0, 4'd8, 3, 64'd9, 1'b0);
    run_one("illegal5", 3'd5, 32'd9, 32'd9, 1'b0, 4'd7, 1, 64'd0, 1'b1);
    run_one("illegal0", 3'd0, 32'd1, 32'd2, 1'b1, 4'd9, 1, 64'd0, 1'b1);

    // Backpressure: tags 0..7 offered back-to-back, each for one cycle
    rsp_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      cmd_valid = 1'b1;
      cmd_opcode = 3'd1;
      cmd_op1 = DW'(t);
      cmd_op2 = 32'd10;
      cmd_sel = 1'b0;
      cmd_tag = TW'(t);
      if (cmd_ready) begin
        acc++;
        exp_q.push_back({1'b0, TW'(t), 64'(t + 10)});
      end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_accepted", 72'(acc), 72'(5));
    check("bp_count", 72'(count), 72'(4));
    check("bp_ready", 72'(cmd_ready), 72'(0));
    check("bp_busy", 72'(busy), 72'(1));
    check("bp_hold_valid", 72'(rsp_valid), 72'(1));
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      if (rsp_valid) begin
        exp_e = exp_q.pop_front();
        check("bp_rsp", 72'({rsp_err, rsp_tag, rsp_data}), 72'(exp_e));
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_left", 72'(exp_q.size()), 72'(0));
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_busy", 72'(busy), 72'(0));
    check("bp_idle_count", 72'(count), 72'(0));

    // Reset during CAPTURE with two commands queued
    push_sum(4'd10, 32'd1, 32'd2);
    push_sum(4'd11, 32'd3, 32'd4);
    push_sum(4'd12, 32'd5, 32'd6);
    check("mid_capture_op", 72'(calc_opcode), 72'(1));
    check("mid_count", 72'(count), 72'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 72'(rsp_valid), 72'(0));
    check("mid_rst_count", 72'(count), 72'(0));
    check("mid_rst_calc", 72'({calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel}), 72'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) acc++;
    end
    check("flush_no_rsp", 72'(acc), 72'(0));
    check("flush_busy", 72'(busy), 72'(0));
    run_one("sum_1_1", 3'd1, 32'd1, 32'd1, 1'b0, 4'd3, 3, 64'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
